// File: rtl/pwm_fader.sv
// Compare-value generator for the PWM stage: ramps o_compare one LSB per
// prescaler tick, either toward a latched target (fade) or as a 0..max triangle (breathe).
module pwm_fader #(
    parameter int RESOLUTION = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [RESOLUTION-1:0] i_top,
    input  logic [RESOLUTION:0]   i_target,
    input  logic                  i_target_valid,
    input  logic                  i_breathe,
    input  logic [DIV_WIDTH-1:0]  i_step_div,
    output logic [RESOLUTION:0]   o_compare,
    output logic                  o_compare_valid,
    output logic                  o_busy,
    output logic [1:0]            o_state
);

    localparam int CW = RESOLUTION + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FADE      = 2'd1,
        BRTH_UP   = 2'd2,
        BRTH_DOWN = 2'd3
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CW-1:0]        target_q;
    logic [CW-1:0]        compare_next;
    logic [CW-1:0]        max_val;
    logic [CW-1:0]        goal;
    logic [DIV_WIDTH-1:0] div_cnt;
    logic                 tick;

    // Full scale is top+1; the extra bit keeps it from overflowing.
    assign max_val = {1'b0, i_top} + CW'(1);
    assign goal    = (target_q < max_val) ? target_q : max_val;
    assign tick    = (state != IDLE) && (div_cnt == i_step_div);
    assign o_busy  = (state != IDLE);
    assign o_state = state;

    always_comb begin
        state_next   = state;
        compare_next = o_compare;
        case (state)
            IDLE: begin
                if (i_breathe) begin
                    state_next = (o_compare < max_val) ? BRTH_UP : BRTH_DOWN;
                end else if (o_compare != goal) begin
                    state_next = FADE;
                end
            end
            FADE: begin
                if (i_breathe) begin
                    state_next = (o_compare < max_val) ? BRTH_UP : BRTH_DOWN;
                end else if (o_compare == goal) begin
                    state_next = IDLE;
                end else if (tick) begin
                    compare_next = (o_compare < goal) ? o_compare + CW'(1)
                                                      : o_compare - CW'(1);
                end
            end
            BRTH_UP: begin
                if (!i_breathe) begin
                    state_next = FADE;
                end else if (o_compare >= max_val) begin
                    state_next = BRTH_DOWN;
                end else if (tick) begin
                    // Turn around on the step that reaches max so the sweep never pauses.
                    compare_next = o_compare + CW'(1);
                    if (o_compare + CW'(1) == max_val) begin
                        state_next = BRTH_DOWN;
                    end
                end
            end
            BRTH_DOWN: begin
                if (!i_breathe) begin
                    state_next = FADE;
                end else if (o_compare == '0) begin
                    state_next = BRTH_UP;
                end else if (tick) begin
                    if (o_compare > max_val) begin
                        compare_next = max_val;
                    end else begin
                        compare_next = o_compare - CW'(1);
                        if (o_compare == CW'(1)) begin
                            state_next = BRTH_UP;
                        end
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= IDLE;
            o_compare       <= '0;
            o_compare_valid <= 1'b0;
            target_q        <= '0;
            div_cnt         <= '0;
        end else begin
            state           <= state_next;
            o_compare       <= compare_next;
            o_compare_valid <= (compare_next != o_compare);
            if (i_target_valid) begin
                target_q <= i_target;
            end
            // Wraps naturally when the divisor is lowered below the running count.
            if ((state == IDLE) || i_target_valid || tick) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DIV_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_pwm_fader.sv
// Self-checking bench for pwm_fader: table-driven fades plus hand-written
// breathe, retarget and reset sequences, checked through an expected-value queue.
module tb_pwm_fader;

    logic        clk;
    logic        rst_n;
    logic [7:0]  top;
    logic [8:0]  target;
    logic        target_valid;
    logic        breathe;
    logic [15:0] step_div;
    logic [8:0]  compare;
    logic        compare_valid;
    logic        busy;
    logic [1:0]  state;

    pwm_fader #(.RESOLUTION(8), .DIV_WIDTH(16)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_top          (top),
        .i_target       (target),
        .i_target_valid (target_valid),
        .i_breathe      (breathe),
        .i_step_div     (step_div),
        .o_compare      (compare),
        .o_compare_valid(compare_valid),
        .o_busy         (busy),
        .o_state        (state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_fail = 0;
    logic [8:0] exp_q[$];
    logic [8:0] cur_exp = '0;
    logic [8:0] prev_cmp = '0;
    int         cyc = 0;
    int         last_pulse = -1;
    bit         gap_en = 1'b0;
    int         gap_exp = 1;

    typedef struct {
        logic [7:0]  top;
        logic [8:0]  target;
        logic        wr;
        logic [15:0] div;
        logic [8:0]  final_val;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_ramp(input logic [8:0] to);
        while (cur_exp != to) begin
            cur_exp = (cur_exp < to) ? cur_exp + 9'd1 : cur_exp - 9'd1;
            exp_q.push_back(cur_exp);
        end
    endtask

    task automatic wait_q(input int bound, input string name);
        bit ok = 1'b0;
        for (int c = 0; c < bound; c++) begin
            step();
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_timeout actual=pending%0d required=pending0", name, exp_q.size());
        end
    endtask

    task automatic wait_done(input int bound, input string name);
        bit ok = 1'b0;
        for (int c = 0; c < bound; c++) begin
            step();
            if (c >= 3 && exp_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_timeout actual=busy%0d_pending%0d required=idle", name, busy, exp_q.size());
        end
    endtask

    // Scoreboard monitor: every valid pulse pops one expected value; any
    // change of o_compare without a pulse is an error.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_cmp = compare;
        end else begin
            if (compare_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {23'd0, compare}, 32'd0 - 1);
                end else begin
                    check("compare_seq", {23'd0, compare}, {23'd0, exp_q.pop_front()});
                end
                if (gap_en && last_pulse >= 0) begin
                    check("step_gap", cyc - last_pulse, gap_exp);
                end
                last_pulse = cyc;
            end else if (compare !== prev_cmp) begin
                check("silent_change", {23'd0, compare}, {23'd0, prev_cmp});
            end
            prev_cmp = compare;
        end
    end

    initial begin
        vecs[0] = '{top: 8'd255, target: 9'd4,   wr: 1'b1, div: 16'd2, final_val: 9'd4};
        vecs[1] = '{top: 8'd255, target: 9'd1,   wr: 1'b1, div: 16'd0, final_val: 9'd1};
        vecs[2] = '{top: 8'd99,  target: 9'd300, wr: 1'b1, div: 16'd1, final_val: 9'd100};
        vecs[3] = '{top: 8'd49,  target: 9'd300, wr: 1'b0, div: 16'd0, final_val: 9'd50};
        vecs[4] = '{top: 8'd49,  target: 9'd50,  wr: 1'b1, div: 16'd0, final_val: 9'd50};
        vecs[5] = '{top: 8'd255, target: 9'd0,   wr: 1'b1, div: 16'd3, final_val: 9'd0};

        rst_n        = 1'b0;
        top          = 8'd255;
        target       = '0;
        target_valid = 1'b0;
        breathe      = 1'b0;
        step_div     = '0;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_compare", {23'd0, compare}, 0);
            check("rst_valid", {31'd0, compare_valid}, 0);
            check("rst_busy", {31'd0, busy}, 0);
        end
        rst_n = 1'b1;
        step();

        // Table-driven fades
        for (int v = 0; v < 6; v++) begin
            int diff;
            diff = (vecs[v].final_val > cur_exp) ? int'(vecs[v].final_val - cur_exp)
                                                 : int'(cur_exp - vecs[v].final_val);
            top          = vecs[v].top;
            step_div     = vecs[v].div;
            target       = vecs[v].target;
            target_valid = vecs[v].wr;
            gap_en       = 1'b1;
            gap_exp      = int'(vecs[v].div) + 1;
            last_pulse   = -1;
            if (vecs[v].final_val == cur_exp) begin
                step();
                target_valid = 1'b0;
                for (int c = 0; c < 8; c++) begin
                    step();
                    check("equal_target_busy", {31'd0, busy}, 0);
                end
            end else begin
                push_ramp(vecs[v].final_val);
                step();
                target_valid = 1'b0;
                wait_done((diff + 2) * (int'(vecs[v].div) + 1) + 20, "fade_vec");
            end
            check("vec_final", {23'd0, compare}, {23'd0, vecs[v].final_val});
            check("vec_busy", {31'd0, busy}, 0);
        end

        // Breathe triangle with top=3 from 0, one step per cycle
        gap_en       = 1'b1;
        gap_exp      = 1;
        last_pulse   = -1;
        top          = 8'd3;
        step_div     = 16'd0;
        breathe      = 1'b1;
        target       = 9'd1;
        target_valid = 1'b1;
        push_ramp(9'd4);
        push_ramp(9'd0);
        push_ramp(9'd1);
        step();
        target_valid = 1'b0;
        wait_q(40, "breathe_seq");
        breathe = 1'b0;
        wait_done(20, "breathe_stop");
        check("breathe_end", {23'd0, compare}, 1);

        // Breathe released at 7 with target 5
        gap_en       = 1'b0;
        top          = 8'd255;
        breathe      = 1'b1;
        target       = 9'd5;
        target_valid = 1'b1;
        push_ramp(9'd7);
        step();
        target_valid = 1'b0;
        wait_q(40, "breathe_to7");
        check("breathe_at7", {23'd0, compare}, 7);
        breathe = 1'b0;
        push_ramp(9'd5);
        wait_done(20, "breathe_off");
        check("breathe_off_final", {23'd0, compare}, 5);

        // Back to 0, then fade toward 10 and retarget to 2 at value 5
        target       = 9'd0;
        target_valid = 1'b1;
        push_ramp(9'd0);
        step();
        target_valid = 1'b0;
        wait_done(40, "fade_to0");
        step_div     = 16'd1;
        target       = 9'd10;
        target_valid = 1'b1;
        push_ramp(9'd5);
        step();
        target_valid = 1'b0;
        wait_q(60, "fade_to5");
        target       = 9'd2;
        target_valid = 1'b1;
        push_ramp(9'd2);
        step();
        target_valid = 1'b0;
        wait_done(40, "retarget");
        check("retarget_final", {23'd0, compare}, 2);

        // Reset asserted mid-fade at value 3
        target       = 9'd10;
        target_valid = 1'b1;
        push_ramp(9'd3);
        step();
        target_valid = 1'b0;
        wait_q(40, "fade_to3");
        rst_n = 1'b0;
        #1;
        check("midrst_compare", {23'd0, compare}, 0);
        check("midrst_valid", {31'd0, compare_valid}, 0);
        check("midrst_busy", {31'd0, busy}, 0);
        cur_exp = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("midrst_hold", {23'd0, compare}, 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("post_rst_compare", {23'd0, compare}, 0);
            check("post_rst_busy", {31'd0, busy}, 0);
        end
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
